// File: rtl/calc_pkg.sv
// calc_pkg: shared FSM states, operator codes and keypad codes for the calculator front end.
package calc_pkg;
    typedef enum logic [1:0] {S_A, S_B, S_ISSUE} state_t;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL} op_t;
    localparam logic [3:0] KEY_SIGN  = 4'hA;
    localparam logic [3:0] KEY_ENTER = 4'hB;
    localparam logic [3:0] KEY_CLEAR = 4'hC;
    localparam logic [3:0] KEY_ADD   = 4'hD;
    localparam logic [3:0] KEY_SUB   = 4'hE;
    localparam logic [3:0] KEY_MUL   = 4'hF;
endpackage

// File: rtl/bcd_to_bin.sv
// bcd_to_bin: signed single BCD digit to 5-bit two's complement; -0 yields 0.
module bcd_to_bin (
    input  logic [3:0] i_bcd,
    input  logic       i_neg,
    output logic [4:0] o_bin
);
    logic [4:0] w_mag;
    assign w_mag = {1'b0, i_bcd};
    assign o_bin = i_neg ? 5'(-w_mag) : w_mag;
endmodule

// File: rtl/operand_entry_ctrl.sv
// operand_entry_ctrl: builds signed operands A and B from keypad events and
// hands them with an operator code to the ALU over valid/ready.
module operand_entry_ctrl
    import calc_pkg::*;
#(
    parameter int         DW         = 5,
    parameter logic [1:0] DEFAULT_OP = 2'd0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          key_valid,
    input  logic [3:0]    key_code,
    input  logic          op_ready,
    output logic          op_valid,
    output logic [DW-1:0] op_a,
    output logic [DW-1:0] op_b,
    output logic [1:0]    op_code,
    output logic [3:0]    disp_digit,
    output logic          disp_sign,
    output logic          entry_sel,
    output logic          busy,
    output logic          err
);
    state_t        r_state, w_state;
    logic [3:0]    r_digit, w_digit;
    logic          r_sign, w_sign;
    logic          r_loaded, w_loaded;
    logic [DW-1:0] r_a, w_a, r_b, w_b;
    logic [1:0]    r_code, w_code;
    logic          r_valid, w_valid, r_busy, w_busy, r_sel, w_sel, r_err, w_err;
    logic [4:0]    w_bin;
    logic [DW-1:0] w_ext;

    bcd_to_bin u_conv (.i_bcd(r_digit), .i_neg(r_sign), .o_bin(w_bin));
    assign w_ext = DW'($signed(w_bin));

    always_comb begin
        w_state  = r_state;
        w_digit  = r_digit;
        w_sign   = r_sign;
        w_loaded = r_loaded;
        w_a      = r_a;
        w_b      = r_b;
        w_code   = r_code;
        w_valid  = r_valid;
        w_busy   = r_busy;
        w_sel    = r_sel;
        w_err    = 1'b0;
        if (r_state == S_ISSUE) begin
            // keys are never honoured while an operation is pending, even on the handshake cycle
            w_err = key_valid;
            if (op_ready) begin
                w_state = S_A;
                w_valid = 1'b0;
                w_busy  = 1'b0;
                w_sel   = 1'b0;
                w_code  = DEFAULT_OP;
            end
        end else if (key_valid) begin
            if (key_code <= 4'd9) begin
                w_digit  = key_code;
                w_loaded = 1'b1;
            end else if (key_code == KEY_SIGN) begin
                w_sign = ~r_sign;
            end else if (key_code == KEY_ENTER) begin
                if (!r_loaded) begin
                    w_err = 1'b1;
                end else begin
                    w_digit  = 4'd0;
                    w_sign   = 1'b0;
                    w_loaded = 1'b0;
                    if (r_state == S_A) begin
                        w_a     = w_ext;
                        w_state = S_B;
                        w_sel   = 1'b1;
                    end else begin
                        w_b     = w_ext;
                        w_state = S_ISSUE;
                        w_valid = 1'b1;
                        w_busy  = 1'b1;
                    end
                end
            end else if (key_code == KEY_CLEAR) begin
                w_digit  = 4'd0;
                w_sign   = 1'b0;
                w_loaded = 1'b0;
                w_a      = '0;
                w_b      = '0;
                w_code   = DEFAULT_OP;
                w_state  = S_A;
                w_sel    = 1'b0;
            end else begin
                w_code = (key_code == KEY_ADD) ? OP_ADD : (key_code == KEY_SUB) ? OP_SUB : OP_MUL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_A;
            r_digit  <= 4'd0;
            r_sign   <= 1'b0;
            r_loaded <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_code   <= DEFAULT_OP;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_sel    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_digit  <= w_digit;
            r_sign   <= w_sign;
            r_loaded <= w_loaded;
            r_a      <= w_a;
            r_b      <= w_b;
            r_code   <= w_code;
            r_valid  <= w_valid;
            r_busy   <= w_busy;
            r_sel    <= w_sel;
            r_err    <= w_err;
        end
    end

    assign op_valid   = r_valid;
    assign op_a       = r_a;
    assign op_b       = r_b;
    assign op_code    = r_code;
    assign disp_digit = r_digit;
    assign disp_sign  = r_sign;
    assign entry_sel  = r_sel;
    assign busy       = r_busy;
    assign err        = r_err;
endmodule

// File: tb/tb_operand_entry_ctrl.sv
// tb_operand_entry_ctrl: directed and random key streams checked every cycle
// against an integer-level model of the operand entry rules.
module tb_operand_entry_ctrl;
    localparam int DW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          key_valid = 1'b0;
    logic [3:0]    key_code = 4'd0;
    logic          op_ready = 1'b0;
    logic          op_valid, disp_sign, entry_sel, busy, err;
    logic [DW-1:0] op_a, op_b;
    logic [1:0]    op_code;
    logic [3:0]    disp_digit;

    int checks = 0;
    int errors = 0;

    // model: phase 0 = entering A, 1 = entering B, 2 = issuing
    int m_ph, m_dig, m_sg, m_ld, m_a, m_b, m_code, m_err;

    operand_entry_ctrl #(.DW(DW), .DEFAULT_OP(2'd0)) dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
        .op_ready(op_ready), .op_valid(op_valid), .op_a(op_a), .op_b(op_b),
        .op_code(op_code), .disp_digit(disp_digit), .disp_sign(disp_sign),
        .entry_sel(entry_sel), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_dig = 0; m_sg = 0; m_ld = 0; m_a = 0; m_b = 0; m_code = 0; m_err = 0;
    endtask

    task automatic model_step(input logic kv, input int kc, input logic rdy);
        int val;
        m_err = 0;
        if (m_ph == 2) begin
            if (kv) m_err = 1;
            if (rdy) begin m_ph = 0; m_code = 0; end
        end else if (kv) begin
            if (kc <= 9) begin
                m_dig = kc; m_ld = 1;
            end else if (kc == 10) begin
                m_sg = 1 - m_sg;
            end else if (kc == 11) begin
                if (m_ld == 0) m_err = 1;
                else begin
                    val = (m_sg != 0) ? -m_dig : m_dig;
                    if (m_ph == 0) m_a = val; else m_b = val;
                    m_ph++;
                    m_dig = 0; m_sg = 0; m_ld = 0;
                end
            end else if (kc == 12) begin
                model_reset();
            end else begin
                m_code = kc - 13;
            end
        end
    endtask

    task automatic check_all();
        chk("op_valid", op_valid, m_ph == 2);
        chk("busy", busy, m_ph == 2);
        chk("entry_sel", entry_sel, m_ph != 0);
        chk("op_a", $signed(op_a), m_a);
        chk("op_b", $signed(op_b), m_b);
        chk("op_code", op_code, m_code);
        chk("disp_digit", disp_digit, m_dig);
        chk("disp_sign", disp_sign, m_sg);
        chk("err", err, m_err);
    endtask

    // drive one cycle of inputs, let the edge happen, compare on the falling edge
    task automatic cyc(input logic kv, input int kc, input logic rdy);
        key_valid = kv;
        key_code  = 4'(kc);
        op_ready  = rdy;
        @(posedge clk);
        model_step(kv, kc, rdy);
        @(negedge clk);
        check_all();
    endtask

    task automatic key(input int kc);
        cyc(1'b1, kc, 1'b0);
    endtask

    task automatic async_reset();
        key_valid = 1'b0;
        op_ready  = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_op_valid", op_valid, 0);
        chk("rst_op_a", op_a, 0);
        chk("rst_disp_digit", disp_digit, 0);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        check_all();
    endtask

    initial begin
        model_reset();
        #12;
        check_all();
        rst_n = 1'b1;
        @(negedge clk);
        check_all();

        key(7); key(11); key(10); key(3); key(11);
        chk("tp1_valid", op_valid, 1);
        chk("tp1_b", $signed(op_b), -3);
        cyc(1'b0, 0, 1'b1);
        chk("tp1_done", op_valid, 0);

        key(10); key(9); key(14); key(11); key(2); key(15); key(11);
        for (int i = 0; i < 5; i++) cyc(1'b0, 0, 1'b0);
        chk("tp2_a", $signed(op_a), -9);
        chk("tp2_code", op_code, 2);
        cyc(1'b0, 0, 1'b1);

        key(11);
        chk("tp3_err", err, 1);
        cyc(1'b0, 0, 1'b0);
        chk("tp3_err_clr", err, 0);

        key(5); key(8); key(10); key(10); key(11);
        chk("tp4_a", $signed(op_a), 8);

        key(10); key(0); key(11);
        chk("tp_minus0", op_b, 0);
        key(12);
        chk("tp5_clear_dropped", op_valid, 1);
        cyc(1'b1, 3, 1'b1);
        cyc(1'b0, 0, 1'b0);

        key(4); key(11); key(6);
        async_reset();

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) async_reset();
            else cyc(1'($urandom_range(0, 2) == 0),
                     ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(9, 11)),
                     1'($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
